// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
//  Package : stack_pkg
//  Shared definitions for the stack machine: stack_op encodings and the
//  default datapath width.
//  Revision: 1.0
// ============================================================================
package stack_pkg;

  // Datapath width shared with the ALU
  localparam int STACK_REG_BITS = 32;

  // Width of the stack_op field
  localparam int OP_BITS = 3;

  // stack_op encodings
  localparam logic [OP_BITS-1:0] OP_NOP   = 3'b000;
  localparam logic [OP_BITS-1:0] OP_PUSH  = 3'b001;
  localparam logic [OP_BITS-1:0] OP_POP   = 3'b010;
  localparam logic [OP_BITS-1:0] OP_BINOP = 3'b011;
  localparam logic [OP_BITS-1:0] OP_UNOP  = 3'b100;
  localparam logic [OP_BITS-1:0] OP_DUP   = 3'b101;
  localparam logic [OP_BITS-1:0] OP_SWAP  = 3'b110;
  localparam logic [OP_BITS-1:0] OP_CLEAR = 3'b111;

endpackage
`default_nettype wire

// File: rtl/operand_stack.sv
`default_nettype none
// ============================================================================
//  Module  : operand_stack
//  Operand stack feeding the ALU: presents TOS/NOS as operands, writes the
//  ALU result back on the same edge, supports push/pop/dup/swap/clear and
//  keeps a sticky overflow/underflow error flag.
//  Revision: 1.0
// ============================================================================
module operand_stack
  import stack_pkg::*;
#(
  parameter int REG_BITS = STACK_REG_BITS,
  parameter int DEPTH    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [OP_BITS-1:0]           stack_op,
  input  logic [REG_BITS-1:0]          push_data,
  input  logic [REG_BITS-1:0]          alu_result,
  output logic [REG_BITS-1:0]          operand1,
  output logic [REG_BITS-1:0]          operand2,
  output logic [REG_BITS-1:0]          tos,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Entry storage; contents beyond count are never observable, so no reset
  logic [REG_BITS-1:0] entry [DEPTH];
  logic [CW-1:0]       count_q;
  logic                err_q;

  // Entry positions relative to the current occupancy
  logic [IW-1:0]       tos_idx;
  logic [IW-1:0]       nos_idx;
  logic [IW-1:0]       push_idx;
  logic                has1;
  logic                has2;
  logic                room;
  logic [REG_BITS-1:0] tos_val;
  logic [REG_BITS-1:0] nos_val;

  // Decoded update controls
  logic                legal;
  logic                clr;
  logic [CW-1:0]       next_count;
  logic                wr_en;
  logic [IW-1:0]       wr_idx;
  logic [REG_BITS-1:0] wr_data;
  logic                sw_en;

  assign tos_idx  = IW'(count_q - CW'(1));
  assign nos_idx  = IW'(count_q - CW'(2));
  assign push_idx = IW'(count_q);
  assign has1     = (count_q != '0);
  assign has2     = (count_q >= CW'(2));
  assign room     = (count_q < DEPTH_C);

  // Read TOS/NOS; an absent entry reads as zero
  always_comb begin
    tos_val = '0;
    nos_val = '0;
    if (has1) tos_val = entry[tos_idx];
    if (has2) nos_val = entry[nos_idx];
  end

  // Legality check and next-state selection for the requested op
  always_comb begin
    legal      = 1'b1;
    clr        = 1'b0;
    next_count = count_q;
    wr_en      = 1'b0;
    wr_idx     = push_idx;
    wr_data    = push_data;
    sw_en      = 1'b0;
    case (stack_op)
      OP_NOP: begin
      end
      OP_PUSH: begin
        if (room) begin
          wr_en      = 1'b1;
          next_count = count_q + CW'(1);
        end else begin
          legal = 1'b0;
        end
      end
      OP_POP: begin
        if (has1) next_count = count_q - CW'(1);
        else      legal      = 1'b0;
      end
      OP_BINOP: begin
        // Result replaces NOS and TOS is dropped
        if (has2) begin
          wr_en      = 1'b1;
          wr_idx     = nos_idx;
          wr_data    = alu_result;
          next_count = count_q - CW'(1);
        end else begin
          legal = 1'b0;
        end
      end
      OP_UNOP: begin
        if (has1) begin
          wr_en   = 1'b1;
          wr_idx  = tos_idx;
          wr_data = alu_result;
        end else begin
          legal = 1'b0;
        end
      end
      OP_DUP: begin
        if (has1 && room) begin
          wr_en      = 1'b1;
          wr_data    = tos_val;
          next_count = count_q + CW'(1);
        end else begin
          legal = 1'b0;
        end
      end
      OP_SWAP: begin
        if (has2) sw_en = 1'b1;
        else      legal = 1'b0;
      end
      OP_CLEAR: begin
        clr        = 1'b1;
        next_count = '0;
      end
      default: begin
      end
    endcase
  end

  // Entry writes; while reset is held count is zero so nothing visible changes
  always_ff @(posedge clk) begin
    if (wr_en) entry[wr_idx] <= wr_data;
    if (sw_en) begin
      entry[tos_idx] <= nos_val;
      entry[nos_idx] <= tos_val;
    end
  end

  // Occupancy and sticky error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= next_count;
      if (clr)         err_q <= 1'b0;
      else if (!legal) err_q <= 1'b1;
    end
  end

  assign operand2 = tos_val;
  assign operand1 = (stack_op == OP_UNOP) ? tos_val : nos_val;
  assign tos      = tos_val;
  assign count    = count_q;
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_stack.sv
`default_nettype none
// ============================================================================
//  Module  : tb_operand_stack
//  Self-checking bench for operand_stack: a queue-based stack model checked
//  every cycle, plus literal expectations from hand-worked sequences.
//  Revision: 1.0
// ============================================================================
module tb_operand_stack;
  import stack_pkg::*;

  localparam int RB = 32;
  localparam int DP = 16;
  localparam int CW = $clog2(DP + 1);

  logic          clk        = 1'b0;
  logic          reset      = 1'b1;
  logic [2:0]    stack_op   = OP_NOP;
  logic [RB-1:0] push_data  = '0;
  logic [RB-1:0] alu_result = '0;
  logic [RB-1:0] operand1;
  logic [RB-1:0] operand2;
  logic [RB-1:0] tos;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          err;

  int checks   = 0;
  int failures = 0;

  // Model state: the stack as a queue (back = top) and the sticky flag
  logic [RB-1:0] mq [$];
  logic          merr = 1'b0;

  operand_stack #(.REG_BITS(RB), .DEPTH(DP)) dut (
    .clk        (clk),
    .reset      (reset),
    .stack_op   (stack_op),
    .push_data  (push_data),
    .alu_result (alu_result),
    .operand1   (operand1),
    .operand2   (operand2),
    .tos        (tos),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .err        (err)
  );

  always #5 clk = ~clk;

  function automatic logic [RB-1:0] m_tos();
    return (mq.size() >= 1) ? mq[mq.size()-1] : '0;
  endfunction

  function automatic logic [RB-1:0] m_nos();
    return (mq.size() >= 2) ? mq[mq.size()-2] : '0;
  endfunction

  task automatic check(input string name, input logic [RB-1:0] act, input logic [RB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one op to the model according to the stack rules
  task automatic model_apply(input logic [2:0] op, input logic [RB-1:0] pd, input logic [RB-1:0] ar);
    logic [RB-1:0] t;
    int n;
    n = mq.size();
    case (op)
      OP_PUSH:  if (n < DP) mq.push_back(pd); else merr = 1'b1;
      OP_POP:   if (n >= 1) void'(mq.pop_back()); else merr = 1'b1;
      OP_BINOP: if (n >= 2) begin
                  void'(mq.pop_back());
                  void'(mq.pop_back());
                  mq.push_back(ar);
                end else merr = 1'b1;
      OP_UNOP:  if (n >= 1) mq[n-1] = ar; else merr = 1'b1;
      OP_DUP:   if (n >= 1 && n < DP) mq.push_back(mq[n-1]); else merr = 1'b1;
      OP_SWAP:  if (n >= 2) begin
                  t       = mq[n-1];
                  mq[n-1] = mq[n-2];
                  mq[n-2] = t;
                end else merr = 1'b1;
      OP_CLEAR: begin
                  mq.delete();
                  merr = 1'b0;
                end
      default: ;
    endcase
  endtask

  // Per-cycle comparison of every output against the model
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("count",    RB'(count), RB'(mq.size()));
        check("tos",      tos,        m_tos());
        check("full",     RB'(full),  RB'(mq.size() == DP));
        check("empty",    RB'(empty), RB'(mq.size() == 0));
        check("err",      RB'(err),   RB'(merr));
        check("operand2", operand2,   m_tos());
        check("operand1", operand1,   (stack_op == OP_UNOP) ? m_tos() : m_nos());
      end
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [RB-1:0] pd, input logic [RB-1:0] ar);
    stack_op   = op;
    push_data  = pd;
    alu_result = ar;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_apply(stack_op, push_data, alu_result);
    stack_op = OP_NOP;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [RB-1:0] pd, input logic [RB-1:0] ar);
    drive(op, pd, ar);
    tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    mq.delete();
    merr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Directed stimulus with literal expectations
  initial begin
    fork
      compare_loop();
    join_none

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_count", RB'(count), 32'd0);
    check("rst_empty", RB'(empty), 32'd1);
    check("rst_full",  RB'(full),  32'd0);
    check("rst_tos",   tos,        32'd0);
    check("rst_err",   RB'(err),   32'd0);
    check("rst_op1",   operand1,   32'd0);
    check("rst_op2",   operand2,   32'd0);

    // 2 + 1
    do_op(OP_PUSH, 32'd2, '0);
    do_op(OP_PUSH, 32'd1, '0);
    do_op(OP_BINOP, '0, m_nos() + m_tos());
    check("add_count", RB'(count), 32'd1);
    check("add_tos",   tos,        32'd3);
    check("add_err",   RB'(err),   32'd0);

    // 1 - 2 with operand ordering a=NOS, b=TOS
    do_op(OP_CLEAR, '0, '0);
    do_op(OP_PUSH, 32'd1, '0);
    do_op(OP_PUSH, 32'd2, '0);
    drive(OP_BINOP, '0, m_nos() - m_tos());
    check("sub_op1", operand1, 32'd1);
    check("sub_op2", operand2, 32'd2);
    tick();
    check("sub_tos", tos, 32'hFFFF_FFFF);

    // Unary NOT
    do_op(OP_CLEAR, '0, '0);
    do_op(OP_PUSH, 32'h0007_FFFF, '0);
    drive(OP_UNOP, '0, ~m_tos());
    check("not_op1", operand1, 32'h0007_FFFF);
    tick();
    check("not_tos",   tos,        32'hFFF8_0000);
    check("not_count", RB'(count), 32'd1);

    // Fill, overflow, then clear with err set
    do_op(OP_CLEAR, '0, '0);
    for (int i = 0; i < DP; i++) do_op(OP_PUSH, RB'(i * 11 + 1), '0);
    check("fill_full", RB'(full), 32'd1);
    do_op(OP_PUSH, 32'hDEAD_BEEF, '0);
    check("ovf_err",   RB'(err),   32'd1);
    check("ovf_count", RB'(count), 32'd16);
    check("ovf_tos",   tos,        32'd166);
    do_op(OP_CLEAR, '0, '0);
    check("clr_count", RB'(count), 32'd0);
    check("clr_err",   RB'(err),   32'd0);
    check("clr_empty", RB'(empty), 32'd1);

    // Underflow boundaries with a single entry preserved
    do_op(OP_UNOP, '0, 32'h1234);
    check("unop_empty_err", RB'(err), 32'd1);
    do_op(OP_CLEAR, '0, '0);
    do_op(OP_PUSH, 32'd9, '0);
    do_op(OP_BINOP, '0, 32'h5555);
    check("binop1_err", RB'(err), 32'd1);
    check("binop1_tos", tos,      32'd9);
    do_op(OP_SWAP, '0, '0);
    check("swap1_count", RB'(count), 32'd1);
    check("swap1_tos",   tos,        32'd9);

    // From reset: pop underflow, then ops keep running with err set
    pulse_reset();
    do_op(OP_POP, '0, '0);
    check("pop_err",   RB'(err),   32'd1);
    check("pop_count", RB'(count), 32'd0);
    do_op(OP_PUSH, 32'd5, '0);
    do_op(OP_PUSH, 32'd7, '0);
    do_op(OP_SWAP, '0, '0);
    check("swap_tos", tos, 32'd5);
    do_op(OP_POP, '0, '0);
    check("pop_tos", tos, 32'd7);
    do_op(OP_DUP, '0, '0);
    check("dup_count", RB'(count), 32'd2);
    check("dup_op1",   operand1,   32'd7);
    check("dup_op2",   operand2,   32'd7);
    check("dup_err",   RB'(err),   32'd1);

    // Asynchronous reset between edges
    do_op(OP_CLEAR, '0, '0);
    do_op(OP_PUSH, 32'd3, '0);
    do_op(OP_PUSH, 32'd4, '0);
    #2;
    reset = 1'b1;
    #1;
    check("async_count", RB'(count), 32'd0);
    check("async_tos",   tos,        32'd0);
    check("async_empty", RB'(empty), 32'd1);
    mq.delete();
    merr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    do_op(OP_PUSH, 32'hA5A5_0001, '0);
    do_op(OP_NOP, '0, '0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
